// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, the NOP encoding and the vector helper.
package fetch_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam int          IRQ_IDX_W = 4;

  // Word-spaced vector slot: base + 4*idx.
  function automatic logic [31:0] irq_vector(input logic [31:0]          base,
                                             input logic [IRQ_IDX_W-1:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings (imem, EX/ID control, IRQ lines).
// master = fetch stage side, slave = pipeline/memory/interrupt-controller side.
interface fetch_stage_if #(
  parameter int NUM_IRQ = 4
);
  logic [31:0]        o_imem_pc;
  logic [31:0]        i_imem_instr;
  logic               i_stall;
  logic               i_flush;
  logic [31:0]        i_redirect_pc;
  logic               i_mret;
  logic               i_ctrl_pending;
  logic [NUM_IRQ-1:0] i_irq;
  logic               i_irq_en;
  logic [NUM_IRQ-1:0] o_irq_ack;
  logic [31:0]        o_epc;
  logic               o_in_isr;
  logic               o_id_valid;
  logic [31:0]        o_id_pc;
  logic [31:0]        o_id_instr;

  modport master (
    output o_imem_pc, o_irq_ack, o_epc, o_in_isr, o_id_valid, o_id_pc, o_id_instr,
    input  i_imem_instr, i_stall, i_flush, i_redirect_pc, i_mret, i_ctrl_pending,
           i_irq, i_irq_en
  );

  modport slave (
    input  o_imem_pc, o_irq_ack, o_epc, o_in_isr, o_id_valid, o_id_pc, o_id_instr,
    output i_imem_instr, i_stall, i_flush, i_redirect_pc, i_mret, i_ctrl_pending,
           i_irq, i_irq_en
  );
endinterface

// File: rtl/fetch_stage_irq_prio_enc.sv
// Fixed-priority interrupt encoder: lowest set request index wins.
// Purely combinational; produces one-hot grant, binary index and an any-request flag.
module irq_prio_enc
  import fetch_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   req,
  output logic [NUM_IRQ-1:0]   grant,
  output logic [IRQ_IDX_W-1:0] idx,
  output logic                 any
);

  // Scan from the top down so the lowest-index request is the last writer.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IRQ_IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fills IF/ID, and handles flush, mret and interrupt entry.
// Define FETCH_VECTORED_IRQ_EN for per-line vectors (TVEC_BASE + 4*idx); otherwise all lines use TVEC_BASE.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TVEC_BASE = 32'h0000_0100,
  parameter int          NUM_IRQ   = 4
) (
  input  logic          i_clk,
  input  logic          in_rst,
  fetch_stage_if.master bus
);

`ifdef FETCH_VECTORED_IRQ_EN
  localparam logic [IRQ_IDX_W-1:0] IDX_MASK = '1;
`else
  localparam logic [IRQ_IDX_W-1:0] IDX_MASK = '0;
`endif

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        epc_q, epc_d;
  logic               id_valid_q, id_valid_d;
  logic [31:0]        id_pc_q, id_pc_d;
  logic [31:0]        id_instr_q, id_instr_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic [NUM_IRQ-1:0]   irq_grant;
  logic [IRQ_IDX_W-1:0] irq_idx;
  logic                 irq_any;
  logic                 trap;
  logic [31:0]          vec_pc;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (bus.i_irq),
    .grant (irq_grant),
    .idx   (irq_idx),
    .any   (irq_any)
  );

  assign vec_pc = irq_vector(TVEC_BASE, irq_idx & IDX_MASK);

  // Trap only on a quiet cycle so the saved epc is never a PC that is about to be squashed.
  assign trap = (state_q == ST_RUN) && bus.i_irq_en && irq_any && !bus.i_ctrl_pending &&
                !bus.i_stall && !bus.i_flush && !bus.i_mret;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    ack_d      = '0;
    if (bus.i_flush) begin
      pc_d       = bus.i_redirect_pc;
      id_valid_d = 1'b0;
    end else if (bus.i_mret) begin
      pc_d       = epc_q;
      id_valid_d = 1'b0;
      if (state_q == ST_ISR) begin
        state_d = ST_RUN;
      end
    end else if (trap) begin
      epc_d      = id_valid_q ? id_pc_q : pc_q;
      pc_d       = vec_pc;
      id_valid_d = 1'b0;
      state_d    = ST_ISR;
      ack_d      = irq_grant;
    end else if (!bus.i_stall) begin
      pc_d       = pc_q + PC_STEP;
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = bus.i_imem_instr;
    end
  end

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.o_imem_pc  = pc_q;
  assign bus.o_epc      = epc_q;
  assign bus.o_id_valid = id_valid_q;
  assign bus.o_id_pc    = id_pc_q;
  assign bus.o_id_instr = id_instr_q;
  assign bus.o_irq_ack  = ack_q;
  assign bus.o_in_isr   = (state_q == ST_ISR);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall/flush, trap entry, mret tail-chain, priority, PC wrap.
module tb_fetch_stage;
  import fetch_pkg::*;

`ifdef FETCH_VECTORED_IRQ_EN
  localparam logic [31:0] VEC0 = 32'h0000_0100;
  localparam logic [31:0] VEC1 = 32'h0000_0104;
  localparam logic [31:0] VEC2 = 32'h0000_0108;
`else
  localparam logic [31:0] VEC0 = 32'h0000_0100;
  localparam logic [31:0] VEC1 = 32'h0000_0100;
  localparam logic [31:0] VEC2 = 32'h0000_0100;
`endif

  logic i_clk = 1'b0;
  logic in_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  fetch_stage_if #(.NUM_IRQ(4)) bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .TVEC_BASE (32'h0000_0100),
    .NUM_IRQ   (4)
  ) dut (
    .i_clk  (i_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  // Memory model: each word encodes its own address.
  assign bus.i_imem_instr = 32'hC0DE_0000 | bus.o_imem_pc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    bus.i_stall        = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_redirect_pc  = '0;
    bus.i_mret         = 1'b0;
    bus.i_ctrl_pending = 1'b0;
    bus.i_irq          = '0;
    bus.i_irq_en       = 1'b1;

    step(); step();
    check("rst_pc",       bus.o_imem_pc,  32'h0);
    check("rst_valid",    bus.o_id_valid, 32'h0);
    check("rst_id_pc",    bus.o_id_pc,    32'h0);
    check("rst_id_instr", bus.o_id_instr, 32'h0000_0013);
    check("rst_epc",      bus.o_epc,      32'h0);
    check("rst_ack",      bus.o_irq_ack,  32'h0);
    check("rst_isr",      bus.o_in_isr,   32'h0);
    in_rst = 1'b1;

    step();
    check("run_pc4",    bus.o_imem_pc,  32'h4);
    check("run_instr0", bus.o_id_instr, 32'hC0DE_0000);
    check("run_valid",  bus.o_id_valid, 32'h1);
    step();
    check("run_pc8",    bus.o_imem_pc,  32'h8);
    check("run_instr4", bus.o_id_instr, 32'hC0DE_0004);
    step(); step();
    check("run_pc10",   bus.o_imem_pc,  32'h10);
    check("run_idpc0c", bus.o_id_pc,    32'hC);

    bus.i_stall = 1'b1;
    step(); step();
    check("stall_pc",    bus.o_imem_pc,  32'h10);
    check("stall_idpc",  bus.o_id_pc,    32'hC);
    check("stall_instr", bus.o_id_instr, 32'hC0DE_000C);
    check("stall_valid", bus.o_id_valid, 32'h1);
    bus.i_flush = 1'b1;
    bus.i_redirect_pc = 32'h40;
    step();
    check("flush_pc",    bus.o_imem_pc,  32'h40);
    check("flush_valid", bus.o_id_valid, 32'h0);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    step();
    check("post_flush_pc",   bus.o_imem_pc,  32'h44);
    check("post_flush_idpc", bus.o_id_pc,    32'h40);
    check("post_flush_vld",  bus.o_id_valid, 32'h1);

    in_rst = 1'b0;
    #2;
    check("async_rst_pc",    bus.o_imem_pc,  32'h0);
    check("async_rst_valid", bus.o_id_valid, 32'h0);
    step();
    in_rst = 1'b1;
    step(); step(); step(); step();
    check("pre_trap_pc",   bus.o_imem_pc,  32'h10);
    check("pre_trap_idpc", bus.o_id_pc,    32'hC);

    bus.i_irq = 4'b0100;
    step();
    check("trap2_epc",   bus.o_epc,      32'hC);
    check("trap2_ack",   bus.o_irq_ack,  32'h4);
    check("trap2_isr",   bus.o_in_isr,   32'h1);
    check("trap2_pc",    bus.o_imem_pc,  VEC2);
    check("trap2_valid", bus.o_id_valid, 32'h0);
    bus.i_irq = 4'b0000;
    step();
    check("trap2_ack_drop", bus.o_irq_ack, 32'h0);
    check("isr_pc",         bus.o_imem_pc, VEC2 + 32'h4);

    bus.i_irq = 4'b0001;
    step(); step();
    check("isr_masked_ack", bus.o_irq_ack, 32'h0);
    check("isr_masked_isr", bus.o_in_isr,  32'h1);
    check("isr_masked_pc",  bus.o_imem_pc, VEC2 + 32'hC);
    bus.i_mret = 1'b1;
    step();
    check("mret_pc",    bus.o_imem_pc,  32'hC);
    check("mret_isr",   bus.o_in_isr,   32'h0);
    check("mret_valid", bus.o_id_valid, 32'h0);
    bus.i_mret = 1'b0;
    step();
    check("chain_ack", bus.o_irq_ack, 32'h1);
    check("chain_epc", bus.o_epc,     32'hC);
    check("chain_pc",  bus.o_imem_pc, VEC0);
    check("chain_isr", bus.o_in_isr,  32'h1);
    bus.i_irq = 4'b0000;
    bus.i_mret = 1'b1;
    step();
    check("mret2_pc", bus.o_imem_pc, 32'hC);
    bus.i_mret = 1'b0;

    bus.i_ctrl_pending = 1'b1;
    bus.i_irq = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pending_ack", bus.o_irq_ack, 32'h0);
      check("pending_isr", bus.o_in_isr,  32'h0);
    end
    check("pending_pc", bus.o_imem_pc, 32'h18);
    bus.i_ctrl_pending = 1'b0;
    step();
    check("unpend_ack", bus.o_irq_ack, 32'h1);
    check("unpend_epc", bus.o_epc,     32'h14);
    check("unpend_pc",  bus.o_imem_pc, VEC0);
    bus.i_irq = 4'b0000;
    bus.i_mret = 1'b1;
    step();
    check("mret3_pc", bus.o_imem_pc, 32'h14);
    bus.i_mret = 1'b0;

    bus.i_irq = 4'b1010;
    step();
    check("prio_ack", bus.o_irq_ack, 32'h2);
    check("prio_epc", bus.o_epc,     32'h14);
    check("prio_pc",  bus.o_imem_pc, VEC1);
    bus.i_irq = 4'b0000;

    bus.i_flush = 1'b1;
    bus.i_mret  = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFFC;
    step();
    check("flush_mret_pc",  bus.o_imem_pc, 32'hFFFF_FFFC);
    check("flush_mret_isr", bus.o_in_isr,  32'h1);
    bus.i_flush = 1'b0;
    bus.i_mret  = 1'b0;
    step();
    check("wrap_pc",    bus.o_imem_pc,  32'h0);
    check("wrap_idpc",  bus.o_id_pc,    32'hFFFF_FFFC);
    check("wrap_valid", bus.o_id_valid, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
